// File: rtl/fetch_queue.sv
// Decoupled instruction fetch: owns the fetch PC, issues one req/ack
// memory request at a time and buffers instructions with their PCs.
module fetch_queue #(
  parameter int ADDR_W = 16,
  parameter int INSTR_W = 16,
  parameter int DEPTH = 4,
  parameter int PC_INC = 2,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         redirect,
  input  logic [ADDR_W-1:0]            redirect_pc,
  input  logic                         halt,
  output logic                         imem_req,
  output logic [ADDR_W-1:0]            imem_addr,
  input  logic                         imem_ack,
  input  logic [INSTR_W-1:0]           imem_rdata,
  output logic                         out_valid,
  output logic [INSTR_W-1:0]           out_instr,
  output logic [ADDR_W-1:0]            out_pc,
  output logic [ADDR_W-1:0]            out_npc,
  input  logic                         out_ready,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);
  localparam logic [ADDR_W-1:0] INC = ADDR_W'(PC_INC);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    DROP
  } state_t;

  state_t state, state_nx;

  logic [ADDR_W-1:0]  fetch_pc, fetch_pc_nx;
  logic [ADDR_W-1:0]  req_addr, req_addr_nx;
  logic [PW-1:0]      wr_ptr, rd_ptr;
  logic [INSTR_W-1:0] instr_mem [DEPTH];
  logic [ADDR_W-1:0]  pc_mem [DEPTH];
  logic               push, pop, issue_ok;
  logic [CW:0]        count_nx;

  assign push = (state == REQ) & imem_ack & ~redirect;
  assign pop = out_valid & out_ready;

  // Occupancy after this edge, ignoring flush; gates the next issue
  assign count_nx = {1'b0, count}
                  + {{CW{1'b0}}, push}
                  - {{CW{1'b0}}, pop};
  assign issue_ok = ~halt & ~redirect
                  & (count_nx < (CW+1)'(DEPTH));

  always_comb begin
    state_nx = state;
    fetch_pc_nx = fetch_pc;
    req_addr_nx = req_addr;
    unique case (state)
      IDLE: begin
        if (redirect) begin
          fetch_pc_nx = redirect_pc;
        end else if (issue_ok) begin
          state_nx = REQ;
          req_addr_nx = fetch_pc;
        end
      end
      REQ: begin
        if (redirect) begin
          fetch_pc_nx = redirect_pc;
          state_nx = imem_ack ? IDLE : DROP;
        end else if (imem_ack) begin
          fetch_pc_nx = req_addr + INC;
          if (issue_ok) req_addr_nx = req_addr + INC;
          else state_nx = IDLE;
        end
      end
      DROP: begin
        if (redirect) fetch_pc_nx = redirect_pc;
        // Stale request completes; its data is thrown away
        if (imem_ack) begin
          if (issue_ok) begin
            state_nx = REQ;
            req_addr_nx = fetch_pc;
          end else begin
            state_nx = IDLE;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      fetch_pc <= RESET_PC;
      req_addr <= RESET_PC;
    end else begin
      state <= state_nx;
      fetch_pc <= fetch_pc_nx;
      req_addr <= req_addr_nx;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else if (redirect) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      count <= count_nx[CW-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      instr_mem[wr_ptr] <= imem_rdata;
      pc_mem[wr_ptr] <= req_addr;
    end
  end

  assign imem_req = (state != IDLE);
  assign imem_addr = req_addr;
  assign out_valid = (count != '0);
  assign out_instr = instr_mem[rd_ptr];
  assign out_pc = pc_mem[rd_ptr];
  assign out_npc = out_pc + INC;

  a_count_bound: assert property (
    @(posedge clk) disable iff (rst) count <= CW'(DEPTH)
  );

endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
- Parametrised decoupled instruction-fetch unit; replaces the single-cycle PC/fetch path ahead of the IF/ID pipeline register.
- Owns the fetch PC and issues one request at a time to a variable-latency instruction memory using a req/ack protocol.
- Buffers returned instructions, with their PCs, in a DEPTH-entry FIFO.
- Supports branch/BR redirect with flush and discard of in-flight data, halt, and decode-side backpressure.

Parameters:
ADDR_W, 16, PC / instruction address width
INSTR_W, 16, instruction word width
DEPTH, 4, FIFO entries; power of two, >= 2
PC_INC, 2, sequential PC increment in bytes
RESET_PC, 0, fetch PC after reset

Ports:
clk  in  1  clock; all state updates on the rising edge
rst  in  1  asynchronous, active-high reset
redirect  in  1  taken branch/BR from decode; flush and refetch
redirect_pc  in  ADDR_W  target PC, sampled when redirect=1
halt  in  1  level; blocks issue of new requests
imem_req  out  1  request valid (registered)
imem_addr  out  ADDR_W  request address, held stable while imem_req=1
imem_ack  in  1  completes the current request; may assert in the first req cycle
imem_rdata  in  INSTR_W  instruction data, valid when imem_ack=1
out_valid  out  1  FIFO head valid
out_instr  out  INSTR_W  head instruction
out_pc  out  ADDR_W  head instruction address
out_npc  out  ADDR_W  out_pc+PC_INC (mod 2^ADDR_W)
out_ready  in  1  consumer accepts the head; pop = out_valid & out_ready
count  out  clog2(DEPTH+1)  FIFO occupancy

Behaviour:
- Reset (async, immediate):
  - state=IDLE, imem_req=0, imem_addr=RESET_PC.
  - fetch_pc=RESET_PC, FIFO pointers=0, count=0, out_valid=0.
  - out_instr/out_pc do not matter while out_valid=0.
- issue_ok = ~halt & ~redirect & (count + push - pop) < DEPTH, evaluated on this cycle's next-count.
- States:
  - IDLE: on issue_ok -> REQ; req_addr<=fetch_pc.
  - REQ: imem_req=1, imem_addr=req_addr.
    - On imem_ack & ~redirect: push {imem_rdata, req_addr}; fetch_pc<=req_addr+PC_INC.
    - Then, if issue_ok, stay in REQ with req_addr<=req_addr+PC_INC (back-to-back, 1 instr/cycle at single-cycle ack); else -> IDLE.
  - DROP: imem_req=1 at the old req_addr until imem_ack. The data is discarded, never pushed. Then -> REQ at fetch_pc if ~halt, else IDLE.
- Redirect (highest priority):
  - FIFO flushes (count=0 next cycle); fetch_pc<=redirect_pc.
  - In REQ without ack -> DROP.
  - In REQ with same-cycle ack -> data discarded, -> IDLE.
  - In IDLE -> IDLE.
  - A redirect in DROP updates fetch_pc and stays in DROP.
  - A pop in the redirect cycle is still a valid consumer handshake.
- Latency: ack in cycle N -> out_valid=1 in cycle N+1. No combinational bypass from imem to out_*.
- Overflow is impossible by construction: issue requires a free slot, so an outstanding request always has room at ack. An assertion covers count<=DEPTH.
- Empty: out_valid=0. out_ready is ignored.
- Full: no issue. Simultaneous push & pop when full cannot occur.
- Push & pop in the same cycle: count unchanged.
- Wrap-around:
  - FIFO pointers wrap mod DEPTH.
  - fetch_pc and out_npc wrap mod 2^ADDR_W. From 0xFFFE with PC_INC=2, the next fetch is 0x0000.
- Halt: no new issue. An outstanding request completes and is pushed (or dropped if redirected). The FIFO keeps draining. Deasserting halt resumes at fetch_pc.
- Reset asserted mid-request drops the request immediately. The memory model must tolerate a withdrawn req.

Test Plan:
- Reset release, ack same cycle as req, out_ready=1, halt=0 -> imem_addr 0x0000,0x0002,0x0004,... on consecutive cycles; out_valid from cycle 2; out_pc tracks with out_npc=out_pc+2.
- out_ready=0, 1-cycle ack -> count reaches 4 and imem_req stays 0 while full; one pop -> a single request at 0x0008, count returns to 4.
- Ack delayed 3 cycles -> imem_addr held stable for all req cycles; one push per ack; count increments by 1.
- Redirect to 0x0100 with count=3 and a request to 0x0006 pending (ack 2 cycles later) -> count=0 next cycle; 0x0006 data never appears; next imem_addr=0x0100; first out_pc=0x0100.
- Redirect in the same cycle as an ack -> acked data discarded; next request at redirect_pc; out_valid stays 0 until that instruction returns.
- redirect_pc=0xFFFE, halt pulse mid-stream, async rst mid-request -> addresses 0xFFFE then 0x0000 (out_npc of 0xFFFE = 0x0000); no issue during halt; resume at the held PC; rst forces imem_req=0, count=0 without a clock edge.
